// File: rtl/frv_gpr_wb_queue.sv
// Write-back arbiter in front of the GPR file write port.
// The primary (in-order) result always wins the port. Secondary (late) results are
// buffered in an in-order FIFO and drain whenever the primary is idle. A starvation
// counter asks upstream to pause the primary so the FIFO can drain.
module frv_gpr_wb_queue #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        p_wen,
    input  logic        p_wide,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_wdata,
    input  logic [31:0] p_wdata_hi,
    input  logic        p_hi_rev,
    output logic        p_stall,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_wide,
    input  logic [4:0]  s_addr,
    input  logic [31:0] s_wdata,
    input  logic [31:0] s_wdata_hi,
    input  logic        s_hi_rev,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rs3_addr,
    output logic        rs1_pend,
    output logic        rs2_pend,
    output logic        rs3_pend,
    output logic        rd_wen,
    output logic        rd_wide,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] rd_wdata_hi,
    output logic        rd_wdata_hi_rev
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic        wide;
        logic [4:0]  addr;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        rev;
    } wb_t;

    wb_t             r_fifo [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_starve;
    wb_t             r_out;
    logic            r_out_wen;

    logic            w_s_ready;
    logic            w_enq;
    logic            w_pop;
    wb_t             w_p_ent;
    wb_t             w_s_ent;
    logic [AW-1:0]   w_off [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [4:0]      w_rs [3];
    logic [2:0]      w_pend;

    // A wide write covers the even/odd pair, so it matches on addr[4:1]; x0 never pends.
    function automatic logic f_match(input logic wide, input logic [4:0] a, input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        return wide ? (a[4:1] == rs[4:1]) : (a == rs);
    endfunction

    // Acceptance depends only on registered occupancy; a pop in the same cycle does not free a slot early.
    assign w_s_ready = (r_cnt < CW'(DEPTH));
    assign s_ready   = w_s_ready && !g_reset;
    // Narrow writes to x0 complete the handshake but are discarded.
    assign w_enq     = s_valid && w_s_ready && (s_wide || (s_addr != 5'd0));
    assign w_pop     = !p_wen && (r_cnt != '0);
    assign p_stall   = (r_starve == SW'(STARVE_LIMIT));

    assign w_p_ent = '{wide: p_wide, addr: p_addr, lo: p_wdata, hi: p_wdata_hi, rev: p_hi_rev};
    assign w_s_ent = '{wide: s_wide, addr: s_addr, lo: s_wdata, hi: s_wdata_hi, rev: s_hi_rev};

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        assign w_off[i] = AW'(i) - r_rd_ptr;
        assign w_vld[i] = (CW'(w_off[i]) < r_cnt);
    end

    assign w_rs[0] = rs1_addr;
    assign w_rs[1] = rs2_addr;
    assign w_rs[2] = rs3_addr;

    // Hazard detect against live FIFO entries and the output register while it is writing.
    always_comb begin
        w_pend = '0;
        for (int r = 0; r < 3; r++) begin
            if (r_out_wen && f_match(r_out.wide, r_out.addr, w_rs[r])) w_pend[r] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_vld[i] && f_match(r_fifo[i].wide, r_fifo[i].addr, w_rs[r])) w_pend[r] = 1'b1;
            end
        end
    end

    assign rs1_pend = w_pend[0];
    assign rs2_pend = w_pend[1];
    assign rs3_pend = w_pend[2];

    // FIFO storage: write at the tail on enqueue.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
        end else if (w_enq) begin
            r_fifo[r_wr_ptr] <= w_s_ent;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; occupancy holds on enqueue+pop.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Count cycles where queued data sat undrained; saturate at the limit.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_starve <= '0;
        end else if ((r_cnt == '0) || w_pop) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Output stage: primary first, then FIFO head; idle cycles keep the data fields.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_out     <= '0;
            r_out_wen <= 1'b0;
        end else if (p_wen) begin
            r_out     <= w_p_ent;
            r_out_wen <= 1'b1;
        end else if (w_pop) begin
            r_out     <= r_fifo[r_rd_ptr];
            r_out_wen <= 1'b1;
        end else begin
            r_out_wen <= 1'b0;
        end
    end

    assign rd_wen          = r_out_wen;
    assign rd_wide         = r_out.wide;
    assign rd_addr         = r_out.addr;
    assign rd_wdata        = r_out.lo;
    assign rd_wdata_hi     = r_out.hi;
    assign rd_wdata_hi_rev = r_out.rev;
endmodule

// File: tb/tb_frv_gpr_wb_queue.sv
// Bench for frv_gpr_wb_queue: a queue-level reference model predicts every register
// file write into a scoreboard; a negedge monitor pops and compares whenever rd_wen
// is seen, and also compares s_ready, p_stall and the pend outputs against the model.
module tb_frv_gpr_wb_queue;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        g_clk, g_reset;
    logic        p_wen, p_wide, p_hi_rev, p_stall;
    logic [4:0]  p_addr;
    logic [31:0] p_wdata, p_wdata_hi;
    logic        s_valid, s_ready, s_wide, s_hi_rev;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata, s_wdata_hi;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
    logic        rs1_pend, rs2_pend, rs3_pend;
    logic        rd_wen, rd_wide, rd_wdata_hi_rev;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;

    frv_gpr_wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .p_wen(p_wen), .p_wide(p_wide), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_wdata_hi(p_wdata_hi), .p_hi_rev(p_hi_rev), .p_stall(p_stall),
        .s_valid(s_valid), .s_ready(s_ready), .s_wide(s_wide), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wdata_hi(s_wdata_hi), .s_hi_rev(s_hi_rev),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
        .rs1_pend(rs1_pend), .rs2_pend(rs2_pend), .rs3_pend(rs3_pend),
        .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rd_wdata_hi(rd_wdata_hi), .rd_wdata_hi_rev(rd_wdata_hi_rev)
    );

    typedef struct {
        bit        wide;
        bit [4:0]  addr;
        bit [31:0] lo;
        bit [31:0] hi;
        bit        rev;
    } ent_t;

    ent_t mq[$];      // secondary entries waiting in the buffer
    ent_t exp_q[$];   // predicted register file writes
    ent_t m_out;
    bit   m_out_wen;
    int   m_starve;
    int   checks, errors;
    bit   last_acc;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_match(input ent_t e, input bit [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        return e.wide ? (e.addr[4:1] == rs[4:1]) : (e.addr == rs);
    endfunction

    function automatic bit m_pend(input bit [4:0] rs);
        foreach (mq[i]) if (m_match(mq[i], rs)) return 1'b1;
        return m_out_wen && m_match(m_out, rs);
    endfunction

    function automatic logic [71:0] pack(input ent_t e);
        return {1'b0, e.wide, e.addr, e.lo, e.hi, e.rev};
    endfunction

    // Reference model: advances once per rising edge from the inputs held across it.
    always @(posedge g_clk) begin
        if (g_reset) begin
            mq.delete(); exp_q.delete();
            m_out_wen = 1'b0; m_starve = 0;
        end else begin
            ent_t pe, se;
            int   sz;
            bit   acc, viol;
            sz  = mq.size();
            acc = s_valid && (sz < DEPTH);
            se  = '{s_wide, s_addr, s_wdata, s_wdata_hi, s_hi_rev};
            if (p_wen) begin
                pe   = '{p_wide, p_addr, p_wdata, p_wdata_hi, p_hi_rev};
                viol = m_pend(p_addr) || (p_wide && m_pend(p_addr ^ 5'd1));
                chk("waw_rule", {71'd0, viol}, 72'd0);
                exp_q.push_back(pe);
                m_out = pe; m_out_wen = 1'b1;
                m_starve = (sz > 0) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else if (sz > 0) begin
                m_out = mq.pop_front();
                exp_q.push_back(m_out);
                m_out_wen = 1'b1; m_starve = 0;
            end else begin
                m_out_wen = 1'b0; m_starve = 0;
            end
            if (acc && (s_wide || s_addr != 5'd0)) mq.push_back(se);
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard and model state.
    always @(negedge g_clk) begin
        if (!g_reset) begin
            chk("s_ready", {71'd0, s_ready}, {71'd0, mq.size() < DEPTH});
            chk("p_stall", {71'd0, p_stall}, {71'd0, m_starve == LIMIT});
            chk("rs1_pend", {71'd0, rs1_pend}, {71'd0, m_pend(rs1_addr)});
            chk("rs2_pend", {71'd0, rs2_pend}, {71'd0, m_pend(rs2_addr)});
            chk("rs3_pend", {71'd0, rs3_pend}, {71'd0, m_pend(rs3_addr)});
            if (rd_wen) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 72'd1, 72'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("wb_data", {1'b0, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, rd_wdata_hi_rev}, pack(e));
                end
            end else begin
                chk("missing_write", 72'(exp_q.size()), 72'd0);
                exp_q.delete();
            end
        end
    end

    task automatic step();
        @(negedge g_clk);
        last_acc = s_ready;
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_s(input bit v, input bit w, input bit [4:0] a, input bit r);
        s_valid = v; s_wide = w; s_addr = a; s_hi_rev = r;
        s_wdata = $urandom; s_wdata_hi = $urandom;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; last_acc = 0;
        g_reset = 1'b1;
        p_wen = 0; p_wide = 0; p_addr = 0; p_wdata = 0; p_wdata_hi = 0; p_hi_rev = 0;
        set_s(0, 0, 0, 0);
        rs1_addr = 0; rs2_addr = 0; rs3_addr = 0;
        repeat (2) @(posedge g_clk);
        #1;
        chk("reset_rd", {1'b0, rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi[31:1]}, 72'd0);
        #1 g_reset = 1'b0;
        @(posedge g_clk); #1;
        chk("reset_ready", {70'd0, s_ready, p_stall}, {70'd0, 2'b10});

        // Primary only: one cycle latency, then idle.
        p_wen = 1; p_addr = 5; p_wdata = 32'hDEADBEEF; p_wdata_hi = 32'h1234_5678;
        step();
        p_wen = 0;
        chk("prim_lat", {1'b0, 38'd0, rd_wen, rd_addr, rd_wdata}, {1'b0, 38'd0, 1'b1, 5'd5, 32'hDEADBEEF});
        step();
        chk("prim_idle", {71'd0, rd_wen}, 72'd0);

        // Secondary fill: five back-to-back writes never see backpressure.
        for (int i = 0; i < 5; i++) begin
            set_s(1, 0, 5'(2 + i), 0);
            step();
            chk("fill_ready", {71'd0, last_acc}, 72'd1);
            if (i == 0) chk("fill_lat0", {71'd0, rd_wen}, 72'd0);
            if (i == 1) chk("fill_lat1", {66'd0, rd_wen, rd_addr}, {66'd0, 1'b1, 5'd2});
        end
        set_s(0, 0, 0, 0);
        repeat (6) step();

        // Full / backpressure with the primary hogging the port.
        n = 0;
        for (int k = 0; k < 14; k++) begin
            p_wen = 1; p_addr = 5'(16 + k); p_wdata = $urandom;
            set_s(1, 0, 5'(2 + n), 0);
            step();
            if (last_acc) n++;
        end
        chk("full_accepts", 72'(n), 72'd4);
        chk("full_ready", {71'd0, s_ready}, 72'd0);
        chk("full_stall", {71'd0, p_stall}, 72'd1);
        p_wen = 0; set_s(0, 0, 0, 0);
        step();
        chk("drain_head", {65'd0, rd_wen, rd_addr, s_ready, p_stall}, {65'd0, 1'b1, 5'd2, 1'b1, 1'b0});
        repeat (5) step();

        // Wide hazard: pair 8/9 pends, 10 does not.
        rs1_addr = 9; rs2_addr = 10;
        set_s(1, 1, 8, 1);
        step();
        set_s(0, 0, 0, 0);
        chk("wide_acc", {71'd0, last_acc}, 72'd1);
        chk("wide_pend", {70'd0, rs1_pend, rs2_pend}, {70'd0, 2'b10});
        step();
        chk("wide_out", {69'd0, rd_wen, rd_wide, rd_wdata_hi_rev}, {69'd0, 3'b111});
        chk("wide_pend_out", {71'd0, rs1_pend}, 72'd1);
        step();
        chk("wide_clear", {71'd0, rs1_pend}, 72'd0);
        rs1_addr = 0; rs2_addr = 0;

        // x0: narrow dropped, wide written.
        set_s(1, 0, 0, 0);
        step();
        set_s(0, 0, 0, 0);
        chk("x0_acc", {71'd0, last_acc}, 72'd1);
        step();
        chk("x0_drop", {70'd0, rd_wen, s_ready}, {70'd0, 2'b01});
        set_s(1, 1, 0, 0);
        step();
        set_s(0, 0, 0, 0);
        step();
        chk("x0_wide", {65'd0, rd_wen, rd_wide, rd_addr}, {65'd0, 1'b1, 1'b1, 5'd0});
        repeat (2) step();

        // Async reset with three entries queued behind the primary.
        for (int k = 0; k < 3; k++) begin
            p_wen = 1; p_addr = 5'(20 + k); p_wdata = $urandom; p_wdata_hi = $urandom;
            set_s(1, 0, 5'(2 + k), 0);
            step();
        end
        rs1_addr = 2; rs2_addr = 3; rs3_addr = 4;
        #1 g_reset = 1'b1;
        #1;
        chk("areset_rd", {1'b0, rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, rd_wdata_hi_rev},
            {1'b0, 71'd0});
        p_wen = 0; set_s(0, 0, 0, 0);
        @(posedge g_clk); #2 g_reset = 1'b0;
        step();
        chk("areset_after", {68'd0, s_ready, rs1_pend, rs2_pend, rs3_pend}, {68'd0, 4'b1000});
        repeat (4) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit [4:0] pa;
            bit       pw, ok;
            rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); rs3_addr = 5'($urandom);
            set_s($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, 5'($urandom), 1'($urandom));
            p_wen = 0;
            if ($urandom_range(0, 9) < (p_stall ? 2 : 4)) begin
                ok = 0;
                for (int t = 0; t < 8 && !ok; t++) begin
                    pa = 5'($urandom); pw = $urandom_range(0, 3) == 0;
                    ok = !m_pend(pa) && !(pw && m_pend(pa ^ 5'd1));
                end
                if (ok) begin
                    p_wen = 1; p_addr = pa; p_wide = pw; p_hi_rev = 1'($urandom);
                    p_wdata = $urandom; p_wdata_hi = $urandom;
                end
            end
            step();
        end
        p_wen = 0; set_s(0, 0, 0, 0);
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
